// File: rtl/commit_map_repair.sv
// commit_map_repair
//   Architectural map table (AMT) maintained at retire time, plus a
//   rename-table repair walk that replays the committed mappings after a
//   flush.
//
//   Each retiring lane frees the physical register that previously held its
//   logical destination and installs its own physical destination. Lanes
//   retiring in the same cycle are resolved oldest-to-youngest, so a younger
//   lane frees the register installed by the nearest older lane with the same
//   destination.
//
//   A recoverFlag_i pulse starts the walk. The walk emits N_REPAIR_PACKETS
//   {logical index, committed mapping} pairs per beat, covering the whole
//   table in SIZE_RMT/N_REPAIR_PACKETS beats. Commits arriving in the
//   recoverFlag_i cycle are applied first and are visible to the walk.
//   Commits arriving during the walk are dropped.
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   commitValid_i     per-lane retire valid, lane 0 oldest
//   commitLogDest_i   per-lane retiring logical destination
//   commitPhyDest_i   per-lane retiring physical destination
//   recoverFlag_i     one-cycle flush pulse, starts or restarts the walk
//   freedPhyReg_o     per-lane {reg_id, valid} returned to the free list
//   repairFlag_o      repair beat valid (registered)
//   repairAddr_o      logical index per packet of the current beat
//   repairData_o      committed mapping per packet of the current beat
//   repairBusy_o      rename must stall (flush cycle through last beat)
//   repairDone_o      one-cycle pulse coincident with the last beat
//
// Configuration
//   FREED_REG_PIPE_EN  when defined, freedPhyReg_o is registered and shows
//                      each freed register one cycle after its commit;
//                      otherwise it is driven combinationally in the commit
//                      cycle.

`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef SIZE_RMT
`define SIZE_RMT 32
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 5
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef N_REPAIR_PACKETS
`define N_REPAIR_PACKETS 4
`endif

package commit_map_repair_pkg;
  typedef struct packed {
    logic [`SIZE_PHYSICAL_LOG-1:0] reg_id;
    logic                          valid;
  } phys_reg;
endpackage

module commit_map_repair
  import commit_map_repair_pkg::*;
(
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [`COMMIT_WIDTH-1:0]                              commitValid_i,
  input  logic [`COMMIT_WIDTH-1:0][`SIZE_RMT_LOG-1:0]           commitLogDest_i,
  input  logic [`COMMIT_WIDTH-1:0][`SIZE_PHYSICAL_LOG-1:0]      commitPhyDest_i,
  input  logic                                                  recoverFlag_i,
  output phys_reg [`COMMIT_WIDTH-1:0]                           freedPhyReg_o,
  output logic                                                  repairFlag_o,
  output logic [`N_REPAIR_PACKETS-1:0][`SIZE_RMT_LOG-1:0]       repairAddr_o,
  output logic [`N_REPAIR_PACKETS-1:0][`SIZE_PHYSICAL_LOG-1:0]  repairData_o,
  output logic                                                  repairBusy_o,
  output logic                                                  repairDone_o
);

  localparam int CW     = `COMMIT_WIDTH;
  localparam int RMT    = `SIZE_RMT;
  localparam int RL     = `SIZE_RMT_LOG;
  localparam int PL     = `SIZE_PHYSICAL_LOG;
  localparam int NPK    = `N_REPAIR_PACKETS;
  localparam int NBEATS = RMT / NPK;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if ((RMT % NPK) != 0) begin : gen_cfg_check
    $error("SIZE_RMT must be a multiple of N_REPAIR_PACKETS");
  end

  typedef enum logic {IDLE, REPAIR} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  beatCnt, beatCntNext;
  logic [PL-1:0]     amt     [RMT];
  logic [PL-1:0]     amtNext [RMT];
  logic              commitEn;
  phys_reg [CW-1:0]  freedReg_p0;

  logic                    repairFlagNext;
  logic                    repairDoneNext;
  logic [NPK-1:0][RL-1:0]  repairAddrNext;
  logic [NPK-1:0][PL-1:0]  repairDataNext;

  // Logical index carried by packet 'lane' of beat 'cnt'.
  function automatic logic [RL-1:0] beatAddr(input logic [CNT_W-1:0] cnt,
                                             input int lane);
    int flat;
    flat = int'(cnt) * NPK + lane;
    return flat[RL-1:0];
  endfunction

  // Commits are only honoured outside the walk; the flush cycle itself is
  // still IDLE, so its commits land before the walk reads the table.
  assign commitEn = !reset && (state == IDLE);

  // Stage p0: freed-register selection, oldest lane first.
  always_comb begin : freed_sel
    for (int j = 0; j < CW; j++) begin
      freedReg_p0[j].reg_id = amt[commitLogDest_i[j]];
      for (int k = 0; k < j; k++) begin
        if (commitValid_i[k] && (commitLogDest_i[k] == commitLogDest_i[j]))
          freedReg_p0[j].reg_id = commitPhyDest_i[k];
      end
      freedReg_p0[j].valid = commitEn && commitValid_i[j];
      if (!freedReg_p0[j].valid)
        freedReg_p0[j].reg_id = '0;
    end
  end

  // Youngest lane is written last, so it owns the entry on a collision.
  always_comb begin : amt_update
    amtNext = amt;
    for (int j = 0; j < CW; j++) begin
      if (commitEn && commitValid_i[j])
        amtNext[commitLogDest_i[j]] = commitPhyDest_i[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RMT; i++)
        amt[i] <= PL'(i);
    end else begin
      amt <= amtNext;
    end
  end

  // Walk FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state   <= stateNext;
      beatCnt <= beatCntNext;
    end
  end

  // Walk FSM: next state. beatCnt is the beat currently on the outputs.
  always_comb begin
    stateNext   = state;
    beatCntNext = beatCnt;
    case (state)
      IDLE: begin
        if (recoverFlag_i) begin
          stateNext   = REPAIR;
          beatCntNext = '0;
        end
      end
      REPAIR: begin
        if (recoverFlag_i) begin
          beatCntNext = '0;
        end else if (beatCnt == LAST_BEAT) begin
          stateNext   = IDLE;
          beatCntNext = '0;
        end else begin
          beatCntNext = beatCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext   = IDLE;
        beatCntNext = '0;
      end
    endcase
  end

  // Walk FSM: outputs. Beat values are prepared from the next state and the
  // post-commit table so the registered beat appears the cycle after entry.
  always_comb begin
    repairFlagNext = (stateNext == REPAIR);
    repairDoneNext = (stateNext == REPAIR) && (beatCntNext == LAST_BEAT);
    for (int k = 0; k < NPK; k++) begin
      repairAddrNext[k] = '0;
      repairDataNext[k] = '0;
      if (stateNext == REPAIR) begin
        repairAddrNext[k] = beatAddr(beatCntNext, k);
        repairDataNext[k] = amtNext[repairAddrNext[k]];
      end
    end
  end

  // Stage p1: registered repair beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      repairFlag_o <= 1'b0;
      repairDone_o <= 1'b0;
      repairAddr_o <= '0;
      repairData_o <= '0;
    end else begin
      repairFlag_o <= repairFlagNext;
      repairDone_o <= repairDoneNext;
      repairAddr_o <= repairAddrNext;
      repairData_o <= repairDataNext;
    end
  end

  assign repairBusy_o = !reset && (recoverFlag_i || (state == REPAIR));

`ifdef FREED_REG_PIPE_EN
  phys_reg [CW-1:0] freedReg_p1;

  // Stage p1: registered free-list return.
  always_ff @(posedge clk) begin
    if (reset)
      freedReg_p1 <= '0;
    else
      freedReg_p1 <= freedReg_p0;
  end

  assign freedPhyReg_o = freedReg_p1;
`else
  assign freedPhyReg_o = freedReg_p0;
`endif

endmodule

// File: tb/tb_commit_map_repair.sv
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef SIZE_RMT
`define SIZE_RMT 32
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 5
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef N_REPAIR_PACKETS
`define N_REPAIR_PACKETS 4
`endif

module tb_commit_map_repair;
  import commit_map_repair_pkg::*;

  localparam int CW     = `COMMIT_WIDTH;
  localparam int RMT    = `SIZE_RMT;
  localparam int RL     = `SIZE_RMT_LOG;
  localparam int PL     = `SIZE_PHYSICAL_LOG;
  localparam int NPK    = `N_REPAIR_PACKETS;
  localparam int NBEATS = RMT / NPK;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset;
  logic [CW-1:0]                 commitValid_i;
  logic [CW-1:0][RL-1:0]         commitLogDest_i;
  logic [CW-1:0][PL-1:0]         commitPhyDest_i;
  logic                          recoverFlag_i;
  phys_reg [CW-1:0]              freedPhyReg_o;
  logic                          repairFlag_o;
  logic [NPK-1:0][RL-1:0]        repairAddr_o;
  logic [NPK-1:0][PL-1:0]        repairData_o;
  logic                          repairBusy_o;
  logic                          repairDone_o;

  commit_map_repair dut (
    .clk             (clk),
    .reset           (reset),
    .commitValid_i   (commitValid_i),
    .commitLogDest_i (commitLogDest_i),
    .commitPhyDest_i (commitPhyDest_i),
    .recoverFlag_i   (recoverFlag_i),
    .freedPhyReg_o   (freedPhyReg_o),
    .repairFlag_o    (repairFlag_o),
    .repairAddr_o    (repairAddr_o),
    .repairData_o    (repairData_o),
    .repairBusy_o    (repairBusy_o),
    .repairDone_o    (repairDone_o)
  );

  typedef struct {
    logic [CW-1:0]         vld;
    logic [CW-1:0][RL-1:0] lg;
    logic [CW-1:0][PL-1:0] ph;
    logic [CW-1:0]         expVld;
    logic [CW-1:0][PL-1:0] expId;
  } vec_t;

  vec_t tbl [7];
  int   modelAmt [RMT];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mkVec(input logic [3:0] v, input int l0, input int l1,
                                 input int l2, input int l3, input int p0, input int p1,
                                 input int p2, input int p3, input logic [3:0] ev,
                                 input int e0, input int e1, input int e2, input int e3);
    vec_t r;
    r.vld = v;
    r.lg[0] = RL'(l0); r.lg[1] = RL'(l1); r.lg[2] = RL'(l2); r.lg[3] = RL'(l3);
    r.ph[0] = PL'(p0); r.ph[1] = PL'(p1); r.ph[2] = PL'(p2); r.ph[3] = PL'(p3);
    r.expVld = ev;
    r.expId[0] = PL'(e0); r.expId[1] = PL'(e1); r.expId[2] = PL'(e2); r.expId[3] = PL'(e3);
    return r;
  endfunction

  task automatic applyModel(input logic [CW-1:0] v, input logic [CW-1:0][RL-1:0] l,
                            input logic [CW-1:0][PL-1:0] p);
    for (int j = 0; j < CW; j++)
      if (v[j]) modelAmt[l[j]] = int'(p[j]);
  endtask

  task automatic chkFreed(input string tag, input logic [CW-1:0] ev,
                          input logic [CW-1:0][PL-1:0] eid);
    for (int j = 0; j < CW; j++) begin
      chk($sformatf("%s_valid%0d", tag, j), 32'(freedPhyReg_o[j].valid), 32'(ev[j]));
      if (ev[j])
        chk($sformatf("%s_id%0d", tag, j), 32'(freedPhyReg_o[j].reg_id), 32'(eid[j]));
    end
  endtask

  task automatic applyVecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      commitValid_i   = tbl[i].vld;
      commitLogDest_i = tbl[i].lg;
      commitPhyDest_i = tbl[i].ph;
`ifdef FREED_REG_PIPE_EN
      @(posedge clk); #1;
      commitValid_i = '0;
`endif
      @(negedge clk);
      chkFreed($sformatf("vec%0d", i), tbl[i].expVld, tbl[i].expId);
      applyModel(tbl[i].vld, tbl[i].lg, tbl[i].ph);
    end
    @(posedge clk); #1;
    commitValid_i = '0;
  endtask

  // One walk: flush cycle (with optional commits), then beats checked
  // against the reference table until the last beat or an injected reset.
  task automatic runWalk(input string tag, input logic [CW-1:0] v0,
                         input logic [CW-1:0][RL-1:0] l0, input logic [CW-1:0][PL-1:0] p0,
                         input int restartAt, input bit junk, input int resetAt,
                         input int expBeats);
    int beat = 0;
    int total = 0;
    bit restarted = 1'b0;
    @(posedge clk); #1;
    recoverFlag_i = 1'b1;
    commitValid_i = v0; commitLogDest_i = l0; commitPhyDest_i = p0;
    @(negedge clk);
    chk({tag, "_busy_c0"}, 32'(repairBusy_o), 32'd1);
    chk({tag, "_flag_c0"}, 32'(repairFlag_o), 32'd0);
    applyModel(v0, l0, p0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      recoverFlag_i = 1'b0;
      commitValid_i = '0;
      reset         = 1'b0;
      if (junk) begin
        commitValid_i   = '1;
        commitLogDest_i = {5'd31, 5'd5, 5'd9, 5'd5};
        commitPhyDest_i = {7'd103, 7'd102, 7'd101, 7'd100};
      end
      if (!restarted && restartAt >= 0 && beat == restartAt) recoverFlag_i = 1'b1;
      if (resetAt >= 0 && beat == resetAt) reset = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_flag_b%0d", tag, beat), 32'(repairFlag_o), 32'd1);
      chk($sformatf("%s_done_b%0d", tag, beat), 32'(repairDone_o), 32'(beat == NBEATS - 1));
      if (!reset)
        chk($sformatf("%s_busy_b%0d", tag, beat), 32'(repairBusy_o), 32'd1);
      for (int k = 0; k < NPK; k++) begin
        chk($sformatf("%s_addr_b%0d_%0d", tag, beat, k), 32'(repairAddr_o[k]),
            32'(beat * NPK + k));
        chk($sformatf("%s_data_b%0d_%0d", tag, beat, k), 32'(repairData_o[k]),
            32'(modelAmt[beat * NPK + k]));
      end
      if (junk)
        for (int j = 0; j < CW; j++)
          chk($sformatf("%s_junkfree_b%0d_%0d", tag, beat, j),
              32'(freedPhyReg_o[j].valid), 32'd0);
      total++;
      if (reset) begin
        for (int i = 0; i < RMT; i++) modelAmt[i] = i;
        break;
      end
      if (recoverFlag_i) begin
        restarted = 1'b1;
        beat = 0;
      end else if (beat == NBEATS - 1) begin
        break;
      end else begin
        beat++;
      end
    end
    chk({tag, "_beats"}, 32'(total), 32'(expBeats));
    @(posedge clk); #1;
    recoverFlag_i = 1'b0;
    commitValid_i = '0;
    reset         = 1'b0;
    @(negedge clk);
    chk({tag, "_flag_end"}, 32'(repairFlag_o), 32'd0);
    chk({tag, "_done_end"}, 32'(repairDone_o), 32'd0);
    chk({tag, "_busy_end"}, 32'(repairBusy_o), 32'd0);
    chk({tag, "_addr_end"}, 32'(repairAddr_o), 32'd0);
    chk({tag, "_data_end"}, 32'(repairData_o), 32'd0);
  endtask

  initial begin
    // Recover and commits held during reset must be overridden by reset.
    reset           = 1'b1;
    recoverFlag_i   = 1'b1;
    commitValid_i   = '1;
    commitLogDest_i = {5'd5, 5'd5, 5'd5, 5'd5};
    commitPhyDest_i = {7'd93, 7'd92, 7'd91, 7'd90};
    for (int i = 0; i < RMT; i++) modelAmt[i] = i;

    //               vld     lane log dest       lane phys dest      expVld  expected freed ids
    tbl[0] = mkVec(4'b0001, 5, 0, 0, 0,      40, 0, 0, 0,        4'b0001, 5, 0, 0, 0);
    tbl[1] = mkVec(4'b0111, 7, 7, 7, 0,      41, 42, 43, 0,      4'b0111, 7, 41, 42, 0);
    tbl[2] = mkVec(4'b1111, 1, 2, 1, 3,      50, 51, 52, 53,     4'b1111, 1, 2, 50, 3);
    tbl[3] = mkVec(4'b1010, 7, 7, 7, 7,      99, 60, 98, 61,     4'b1010, 0, 43, 0, 60);
    tbl[4] = mkVec(4'b1001, 0, 0, 31, 31,    44, 0, 0, 45,       4'b1001, 0, 0, 0, 31);
    tbl[5] = mkVec(4'b0100, 0, 0, 5, 0,      0, 0, 46, 0,        4'b0100, 0, 0, 40, 0);
    tbl[6] = mkVec(4'b0111, 5, 9, 7, 0,      47, 48, 49, 0,      4'b0111, 5, 9, 7, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(repairBusy_o), 32'd0);
    chk("rst_flag", 32'(repairFlag_o), 32'd0);
    chk("rst_done", 32'(repairDone_o), 32'd0);
    chk("rst_addr", 32'(repairAddr_o), 32'd0);
    chk("rst_data", 32'(repairData_o), 32'd0);
    for (int j = 0; j < CW; j++)
      chk($sformatf("rst_freed%0d", j), 32'(freedPhyReg_o[j].valid), 32'd0);

    @(posedge clk); #1;
    reset         = 1'b0;
    recoverFlag_i = 1'b0;
    commitValid_i = '0;
    @(negedge clk);
    chk("post_rst_flag", 32'(repairFlag_o), 32'd0);
    chk("post_rst_busy", 32'(repairBusy_o), 32'd0);

    applyVecs(0, 1);
    runWalk("walk1", '0, '0, '0, -1, 1'b0, -1, NBEATS);
    applyVecs(1, 6);
    runWalk("walk2", 4'b0011, {5'd0, 5'd0, 5'd9, 5'd9}, {7'd0, 7'd0, 7'd71, 7'd70},
            -1, 1'b0, -1, NBEATS);
    runWalk("walk3", '0, '0, '0, 3, 1'b1, -1, 4 + NBEATS);
    runWalk("walk4", '0, '0, '0, -1, 1'b0, -1, NBEATS);
    runWalk("walk5", '0, '0, '0, -1, 1'b0, 5, 6);
    applyVecs(6, 7);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
